// File: rtl/set_op_sequencer.sv
// Set-compare sequencer: SEQ/SNE/SLT/SGT/SLE/SGE over one shared CHUNK-bit subtractor, LSB-first.
// Optional macro SET_OP_UNSIGNED_EN adds SLTU (op 110) and SGTU (op 111).
module set_op_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             illegal_op
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] nb_sh;
    logic             a_msb;
    logic             b_msb;
    logic             carry;
    logic             nz;
    logic [CW-1:0]    cnt;
    logic [31:0]      result_r;
    logic             illegal_r;

    logic [CHUNK:0]   sum;
    logic             last;
    logic             nz_f;
    logic             carry_f;
    logic             diff_msb;
    logic             s;
    logic             lt;
    logic             gt;
    logic             pred;
    logic             illegal_next;

    // Operands are shifted right each slice so the adder always sees the low chunk.
    assign sum      = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, nb_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    assign last     = (cnt == CW'(NCHUNK - 1));
    assign nz_f     = nz | (|sum[CHUNK-1:0]);
    assign carry_f  = sum[CHUNK];
    assign diff_msb = sum[CHUNK-1];

    // Mixed signs are decided by the sign bits alone; same-sign differences cannot overflow.
    assign s  = a_msb ^ b_msb;
    assign lt = s ? a_msb : diff_msb;
    assign gt = s ? b_msb : (~diff_msb & nz_f);

    always_comb begin
        pred         = 1'b0;
        illegal_next = 1'b0;
        case (op_r)
            3'b000: pred = ~nz_f;
            3'b001: pred = nz_f;
            3'b010: pred = lt;
            3'b011: pred = gt;
            3'b100: pred = ~gt;
            3'b101: pred = ~lt;
`ifdef SET_OP_UNSIGNED_EN
            3'b110: pred = ~carry_f;
            3'b111: pred = carry_f & nz_f;
`endif
            default: illegal_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SUB;
                end
            end
            SUB: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The predicate is registered on the final slice so result stays stable through backpressure.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r      <= 3'b000;
            a_sh      <= '0;
            nb_sh     <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            carry     <= 1'b1;
            nz        <= 1'b0;
            cnt       <= '0;
            result_r  <= '0;
            illegal_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r  <= op;
                        a_sh  <= a;
                        nb_sh <= ~b;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        carry <= 1'b1;
                        nz    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SUB: begin
                    carry <= carry_f;
                    nz    <= nz_f;
                    a_sh  <= a_sh >> CHUNK;
                    nb_sh <= nb_sh >> CHUNK;
                    if (last) begin
                        result_r  <= {31'b0, pred & ~illegal_next};
                        illegal_r <= illegal_next;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result     = result_r;
    assign illegal_op = illegal_r;

endmodule

// File: tb/tb_set_op_sequencer.sv
// Scoreboard bench for set_op_sequencer: driver pushes model results, negedge monitor pops and compares.
module tb_set_op_sequencer;

    localparam int WIDTH  = 32;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      result;
    logic             illegal_op;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   cyc       = 0;
    bit   seen_valid = 0;
    bit   rand_ready = 0;
    bit   b_done     = 0;

    set_op_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference semantics straight from the predicate definitions, using native compares.
    function automatic logic [32:0] ref_model(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
        logic signed [WIDTH-1:0] sx;
        logic signed [WIDTH-1:0] sy;
        logic                    bit0;
        logic                    ill;
        sx   = x;
        sy   = y;
        bit0 = 1'b0;
        ill  = 1'b0;
        case (o)
            3'd0: bit0 = (x == y);
            3'd1: bit0 = (x != y);
            3'd2: bit0 = (sx < sy);
            3'd3: bit0 = (sx > sy);
            3'd4: bit0 = (sx <= sy);
            3'd5: bit0 = (sx >= sy);
`ifdef SET_OP_UNSIGNED_EN
            3'd6: bit0 = (x < y);
            3'd7: bit0 = (x > y);
`endif
            default: ill = 1'b1;
        endcase
        return {ill, 31'b0, bit0};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y);
        bit          acc;
        logic [32:0] m;
        exp_t        e;
        @(posedge clk);
        #1;
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        acc      = 0;
        for (int w = 0; w < 100 && !acc; w++) begin
            @(negedge clk);
            if (in_ready) acc = 1;
        end
        if (acc) begin
            m     = ref_model(o, x, y);
            e.res = m[31:0];
            e.ill = m[32];
            e.acc = cyc;
            sb.push_back(e);
        end else begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        op       = 3'($urandom);
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int w = 0; w < 300 && !ok; w++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) ok = 1;
        end
        if (!ok) checkOutput("drain_timeout", 64'd0, 64'd1);
    endtask

    // Monitor: latency on the first out_valid cycle, scoreboard compare on each handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", {63'b0, out_valid}, 64'd0);
            end else begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    checkOutput("latency", 64'(cyc - sb[0].acc), 64'(NCHUNK + 1));
                end
                if (out_ready) begin
                    checkOutput("result", {31'b0, illegal_op, result}, {31'b0, sb[0].ill, sb[0].res});
                    void'(sb.pop_front());
                    seen_valid = 0;
                end
            end
        end else begin
            seen_valid = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom % 4) != 0;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [32:0]      m;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        bit               ok;
        bit               seen;

        rst_n     = 1'b0;
        in_valid  = 1'b1;
        op        = 3'd2;
        a         = 32'h1;
        b         = 32'h2;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_state", {60'b0, in_ready, out_valid, illegal_op, 1'b0} | {32'b0, result},
                    {60'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checkOutput("no_capture_in_reset", {62'b0, in_ready, out_valid}, {62'b0, 1'b1, 1'b0});

        $display("[TB] directed vectors");
        applyStimulus(3'd2, 32'hFFFFFFFF, 32'h1);
        applyStimulus(3'd3, 32'hFFFFFFFF, 32'h1);
        applyStimulus(3'd0, 32'h12345678, 32'h12345678);
        applyStimulus(3'd1, 32'h12345678, 32'h12345678);
        applyStimulus(3'd5, 32'h12345678, 32'h12345678);
        applyStimulus(3'd4, 32'h12345678, 32'h12345678);
        applyStimulus(3'd1, 32'h01000000, 32'h0);
        applyStimulus(3'd3, 32'h7FFFFFFF, 32'h80000000);
        applyStimulus(3'd2, 32'h7FFFFFFF, 32'h80000000);
        applyStimulus(3'd2, 32'h80000000, 32'h7FFFFFFF);
        applyStimulus(3'd6, 32'h1, 32'h2);
        applyStimulus(3'd7, 32'hFFFFFFFF, 32'h1);
        drain();

        $display("[TB] backpressure");
        out_ready = 1'b0;
        m = ref_model(3'd3, 32'h00000005, 32'hFFFFFFFB);
        applyStimulus(3'd3, 32'h00000005, 32'hFFFFFFFB);
        b_done = 0;
        fork
            begin
                applyStimulus(3'd0, 32'hCAFEF00D, 32'hCAFEF00D);
                b_done = 1;
            end
        join_none
        ok = 0;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (out_valid) ok = 1;
        end
        if (!ok) checkOutput("bp_valid_timeout", 64'd0, 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("bp_hold", {29'b0, out_valid, in_ready, illegal_op, result},
                        {29'b0, 1'b1, 1'b0, m[32], m[31:0]});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        ok = 0;
        for (int w = 0; w < 100 && !ok; w++) begin
            @(negedge clk);
            if (b_done && sb.size() == 0) ok = 1;
        end
        if (!ok) checkOutput("bp_pending_timeout", 64'd0, 64'd1);
        drain();

        $display("[TB] reset abort");
        @(posedge clk);
        #1;
        op       = 3'd0;
        a        = 32'h0;
        b        = 32'h0;
        in_valid = 1'b1;
        ok = 0;
        for (int w = 0; w < 20 && !ok; w++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        checkOutput("reset_abort", {62'b0, seen, in_ready}, {62'b0, 1'b0, 1'b1});

        $display("[TB] random vectors");
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            case ($urandom % 5)
                0: begin x = $urandom; y = x; end
                1: begin x = 32'h80000000; y = ($urandom % 2) ? 32'h7FFFFFFF : 32'hFFFFFFFF; end
                2: begin x = $urandom; y = x ^ (32'h1 << ($urandom % 32)); end
                default: begin x = $urandom; y = $urandom; end
            endcase
            applyStimulus(3'($urandom), x, y);
        end
        rand_ready = 0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/set_op_sequencer.md
Name: set_op_sequencer

Overview:
- Multi-cycle controller that evaluates the set-compare family (SEQ, SNE, SLT, SGT, SLE, SGE) on two WIDTH-bit operands using one shared CHUNK-bit subtractor slice, iterated LSB-first.
- Derives the difference MSB and a nonzero flag, then forms a 32-bit 0/1 result.
- Sits between the issue stage and writeback as a valid/ready unit, so the ALU needs no full-width comparator.

Parameters:
- WIDTH, 32, operand width; must be a multiple of CHUNK.
- CHUNK, 8, subtractor slice width; NCHUNK = WIDTH/CHUNK slice cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  request present
- in_ready  output  1  unit can accept a request
- op  input  3  000 SEQ, 001 SNE, 010 SLT, 011 SGT, 100 SLE, 101 SGE, 110/111 see Optional Feature
- a  input  WIDTH  operand A (signed)
- b  input  WIDTH  operand B (signed)
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- result  output  32  bit 0 = predicate, bits 31:1 = 0
- illegal_op  output  1  qualifies result; high when op was unsupported

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, in_ready=1, out_valid=0, result=0, illegal_op=0, chunk counter=0, carry=1, nz=0.
- Reset asserted mid-operation aborts the operation. Its result is never presented.
- IDLE:
  - in_ready=1.
  - On in_valid: capture op, a, ~b, a_msb, b_msb; set carry=1, nz=0, cnt=0; go to SUB.
- SUB:
  - in_ready=0.
  - Each cycle, slice sum = a[cnt] + ~b[cnt] + carry. Store carry-out, and nz |= |sum.
  - On the last slice (cnt=NCHUNK-1), latch diff_msb = sum[CHUNK-1]; otherwise increment cnt.
  - Exactly NCHUNK cycles, then go to DONE.
- DONE:
  - out_valid=1; result and illegal_op are stable until the handshake.
  - On out_ready: out_valid drops next cycle and the state returns to IDLE.
  - in_ready=0 while in DONE. No new acceptance in the same cycle as the result handoff.
- Latency and throughput:
  - Acceptance at edge 0; out_valid high after edge NCHUNK+1 (5 cycles at defaults).
  - Throughput is one operation per NCHUNK+2 cycles when out_ready is held high.
- Predicates (s = a_msb ^ b_msb):
  - lt = s ? a_msb : diff_msb
  - gt = s ? b_msb : (!diff_msb & nz)
  - SEQ = !nz, SNE = nz, SLT = lt, SGT = gt, SLE = !gt, SGE = !lt
- Arithmetic boundaries:
  - Same-sign subtraction cannot overflow, so diff_msb is exact.
  - Mixed signs are decided by s alone. This covers a = 0x80000000, b = 0x7FFFFFFF.
- Unsupported op (110/111 without the macro): result=0 and illegal_op=1 in DONE. Latency is unchanged.
- in_valid held during SUB/DONE is ignored: no capture and no corruption. The request stays pending until in_ready=1.
- Operands are registered at acceptance. Input changes after acceptance have no effect.

Optional Feature:
- Macro SET_OP_UNSIGNED_EN.
- When defined:
  - op 110 = SLTU: result bit0 = !final_carry (borrow).
  - op 111 = SGTU: result bit0 = final_carry & nz.
  - illegal_op is never set.
- When undefined: 110/111 are illegal as described above, and no extra logic is generated.

Test Plan:
- Reset with in_valid=1 → in_ready=1, out_valid=0, result=0. No capture while rst_n=0.
- SLT, a=0xFFFFFFFF (-1), b=1, accepted at cycle 0 → out_valid at cycle 5, result=0x00000001, illegal_op=0. The same operands with SGT → 0x00000000.
- SEQ, a=b=0x12345678 → result=1. SNE with the same operands → 0. SGE → 1. SLE → 1. Check nz across all 4 chunks with a=0x01000000, b=0 under SNE → 1.
- Mixed-sign extremes, SGT, a=0x7FFFFFFF, b=0x80000000 → 1. SLT with the same operands → 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → result stable, in_ready=0, and a new in_valid is ignored. out_ready=1 → IDLE the next cycle, then the pending request is accepted.
- op=110, a=1, b=2:
  - Without SET_OP_UNSIGNED_EN → result=0, illegal_op=1.
  - With SET_OP_UNSIGNED_EN → result=1, illegal_op=0.
  - With the macro, a=0xFFFFFFFF, b=1, op=111 → 1.
  - Reset pulsed at cycle 2 of SUB → out_valid never asserts.
